// File: rtl/arb_pkg.sv
// Shared state encodings for the round-robin grant arbiter.
package arb_pkg;

  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT   = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             any
);

  int idx;

  // Walk from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        winner = idx[IDW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter FSM with registered one-hot grant and a Mealy arbitration strobe.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             req_ack,
  output logic             timeout
);

  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   pick_id;
  logic             pick_any;

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           timeout_q, timeout_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_GRANT;
          grant_d    = ONE_HOT_0 << pick_id;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!req[grant_id_q]) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
          state_d   = ARB_RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      ARB_RELEASE: begin
        // The owner just served becomes lowest priority at the next arbitration.
        ptr_d      = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        grant_id_d = '0;
        state_d    = ARB_IDLE;
      end
      default: begin
        state_d    = ARB_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign req_ack  = (state_q == ARB_IDLE) && (|req);
`ifdef ARB_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule
